irq_csr_unit: RTL and testbench

- Parametrised machine-mode CSR and interrupt unit for the 3-stage RV32 core; successor to the single-interrupt csr block.
- Sits in the memory/writeback (MW) stage. Takes NUM_IRQ external interrupt channels, each with a per-channel edge/level mode, and supports direct or vectored mtvec.
- Provides CSR read/write/set/clear, trap entry, mret, and a 64-bit mcycle counter.
- Drives the PC redirect mux and the MW-stage kill.

---
 rtl/irq_csr_unit.sv | 215 +++++++++++++++++++++
 tb/tb_irq_csr_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_csr_unit.sv
// Machine-mode CSR file and interrupt unit for the MW stage of the 3-stage RV32 core.
// Handles NUM_IRQ external interrupt channels, each either edge-latched or level-sampled,
// with direct or vectored mtvec. Provides CSR read/write/set/clear, trap entry, mret
// and a 64-bit mcycle counter. Every output is combinational from state and inputs.
module irq_csr_unit #(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter logic [31:0]        MTVEC_RST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               instr_valid,
  input  logic [31:0]        pc_in,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic [1:0]         csr_op,
  input  logic               is_mret,
  output logic [31:0]        csr_rdata,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               kill_mw,
  output logic               trap_taken
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

  // Architectural state
  logic               mst_mie;
  logic               mst_mpie;
  logic [NUM_IRQ-1:0] mie_field;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] irq_p1;
  logic [31:0]        mtvec;
  logic [31:0]        mscratch;
  logic [31:0]        mepc;
  logic [31:0]        mcause;
  logic [63:0]        mcycle;

  // Combinational control
  logic [NUM_IRQ-1:0] pend_en;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mip_clr;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [3:0]         sel;
  logic [31:0]        cause_code;
  logic [31:0]        tvec_base;
  logic [31:0]        trap_pc;
  logic [31:0]        csr_new;
  logic               trap;
  logic               mret_go;
  logic               csr_we;

  // Lowest set bit index; lower channel numbers have higher priority.
  function automatic logic [3:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Reserved mtvec modes 2 and 3 legalise to direct mode.
  function automatic logic [31:0] mtvec_legal(input logic [31:0] v);
    return {v[31:2], (v[1] ? 2'b00 : v[1:0])};
  endfunction

  // Read-modify-write operand for write / set / clear.
  function automatic logic [31:0] csr_alu(input logic [1:0]  op,
                                          input logic [31:0] old,
                                          input logic [31:0] wd);
    logic [31:0] r;
    case (op)
      2'b01:   r = wd;
      2'b10:   r = old | wd;
      2'b11:   r = old & ~wd;
      default: r = old;
    endcase
    return r;
  endfunction

  // CSR read mux; returns the pre-edge value, so read-during-write sees old data.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3] = mst_mie;
        csr_rdata[7] = mst_mpie;
      end
      ADDR_MIE:      csr_rdata[16 +: NUM_IRQ] = mie_field;
      ADDR_MTVEC:    csr_rdata = mtvec;
      ADDR_MSCRATCH: csr_rdata = mscratch;
      ADDR_MEPC:     csr_rdata = mepc;
      ADDR_MCAUSE:   csr_rdata = mcause;
      ADDR_MIP:      csr_rdata[16 +: NUM_IRQ] = pend;
      ADDR_MCYCLE:   csr_rdata = mcycle[31:0];
      ADDR_MCYCLEH:  csr_rdata = mcycle[63:32];
      default:       csr_rdata = '0;
    endcase
  end

  // Trap decision, priority select and redirect target.
  always_comb begin
    pend_en    = pend & mie_field;
    trap       = instr_valid & mst_mie & (|pend_en);
    mret_go    = instr_valid & is_mret & ~trap;
    csr_we     = instr_valid & ~trap & ~is_mret & (csr_op != 2'b00);
    sel        = lowest_idx(pend_en);
    cause_code = 32'd16 + {28'd0, sel};
    tvec_base  = {mtvec[31:2], 2'b00};
    trap_pc    = (mtvec[1:0] == 2'b01) ? (tvec_base + (cause_code << 2)) : tvec_base;
    csr_new    = csr_alu(csr_op, csr_rdata, csr_wdata);
  end

  // Next pending state: edge channels latch rising edges (an edge beats a same-cycle
  // software clear), level channels simply follow the registered request.
  always_comb begin
    rise     = irq_i & ~irq_p1;
    mip_clr  = '0;
    pend_nxt = '0;
    if (csr_we && (csr_addr == ADDR_MIP)) mip_clr = ~csr_new[16 +: NUM_IRQ];
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) pend_nxt[i] = rise[i] | (pend[i] & ~mip_clr[i]);
      else              pend_nxt[i] = irq_i[i];
    end
  end

  // Output drive: trap wins over mret; nothing asserts without a valid instruction.
  always_comb begin
    redirect    = trap | mret_go;
    kill_mw     = trap;
    trap_taken  = trap;
    redirect_pc = '0;
    if (trap)         redirect_pc = trap_pc;
    else if (mret_go) redirect_pc = mepc;
  end

  // Interrupt request history and pending latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_p1 <= '0;
      pend   <= '0;
    end else begin
      irq_p1 <= irq_i;
      pend   <= pend_nxt;
    end
  end

  // mstatus MIE/MPIE: trap stacks, mret unstacks, otherwise software writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
    end else if (trap) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (mret_go) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (csr_we && (csr_addr == ADDR_MSTATUS)) begin
      mst_mie  <= csr_new[3];
      mst_mpie <= csr_new[7];
    end
  end

  // Software-only registers: mie, mtvec, mscratch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_field <= '0;
      mtvec     <= MTVEC_RST;
      mscratch  <= '0;
    end else if (csr_we) begin
      if (csr_addr == ADDR_MIE)      mie_field <= csr_new[16 +: NUM_IRQ];
      if (csr_addr == ADDR_MTVEC)    mtvec     <= mtvec_legal(csr_new);
      if (csr_addr == ADDR_MSCRATCH) mscratch  <= csr_new;
    end
  end

  // Trap record: mepc/mcause are captured on trap entry or written by software.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mepc   <= '0;
      mcause <= '0;
    end else if (trap) begin
      mepc   <= pc_in;
      mcause <= {1'b1, cause_code[30:0]};
    end else if (csr_we) begin
      if (csr_addr == ADDR_MEPC)   mepc   <= {csr_new[31:2], 2'b00};
      if (csr_addr == ADDR_MCAUSE) mcause <= csr_new;
    end
  end

  // Free-running cycle counter; a write to either half replaces it and skips the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle <= '0;
    end else if (csr_we && (csr_addr == ADDR_MCYCLE)) begin
      mcycle[31:0] <= csr_new;
    end else if (csr_we && (csr_addr == ADDR_MCYCLEH)) begin
      mcycle[63:32] <= csr_new;
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

endmodule

// File: tb/tb_irq_csr_unit.sv
// Directed bench for irq_csr_unit: channels 0 and 2 edge-triggered, 1 and 3 level.
module tb_irq_csr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_i;
  logic        instr_valid;
  logic [31:0] pc_in;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic        is_mret;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        kill_mw;
  logic        trap_taken;

  int tests = 0;
  int fails = 0;

  irq_csr_unit #(
    .NUM_IRQ   (4),
    .EDGE_MASK (4'b0101),
    .MTVEC_RST (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_i       (irq_i),
    .instr_valid (instr_valid),
    .pc_in       (pc_in),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_op      (csr_op),
    .is_mret     (is_mret),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .kill_mw     (kill_mw),
    .trap_taken  (trap_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One valid CSR instruction, then idle.
  task automatic op(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
    @(negedge clk);
    instr_valid = 1'b1; csr_addr = a; csr_op = o; csr_wdata = d; is_mret = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0; csr_op = 2'b00;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; irq_i = '0; instr_valid = 1'b0; pc_in = '0;
    csr_addr = 12'h305; csr_wdata = '0; csr_op = 2'b00; is_mret = 1'b0;
    #1;
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_kill", {31'd0, kill_mw}, 32'd0);
    chk("rst_trap", {31'd0, trap_taken}, 32'd0);
    chk("rst_mtvec", csr_rdata, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Direct mode, channel 0 edge trap
    op(12'h305, 2'b01, 32'h100);
    op(12'h304, 2'b01, 32'h0001_0000);
    op(12'h300, 2'b10, 32'h8);
    rd("mstatus_set", 12'h300, 32'h8);
    rd("mie_wr", 12'h304, 32'h0001_0000);
    @(negedge clk);
    irq_i = 4'b0001; instr_valid = 1'b1; pc_in = 32'h40;
    #1;
    chk("no_trap_before_latch", {31'd0, trap_taken}, 32'd0);
    @(negedge clk);
    irq_i = 4'b0000;
    #1;
    chk("trap0_taken", {31'd0, trap_taken}, 32'd1);
    chk("trap0_redirect", {31'd0, redirect}, 32'd1);
    chk("trap0_kill", {31'd0, kill_mw}, 32'd1);
    chk("trap0_pc", redirect_pc, 32'h100);
    @(negedge clk);
    instr_valid = 1'b0;
    rd("trap0_mepc", 12'h341, 32'h40);
    rd("trap0_mcause", 12'h342, 32'h8000_0010);
    rd("trap0_mstatus", 12'h300, 32'h80);

    // mret back to mepc
    @(negedge clk);
    instr_valid = 1'b1; is_mret = 1'b1; pc_in = 32'h44;
    #1;
    chk("mret_redirect", {31'd0, redirect}, 32'd1);
    chk("mret_pc", redirect_pc, 32'h40);
    chk("mret_kill", {31'd0, kill_mw}, 32'd0);
    chk("mret_trap", {31'd0, trap_taken}, 32'd0);
    @(negedge clk);
    instr_valid = 1'b0; is_mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h88);

    // Trap beats a same-cycle mscratch write
    @(negedge clk);
    instr_valid = 1'b1; csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'hDEAD; pc_in = 32'h80;
    #1;
    chk("trapop_kill", {31'd0, kill_mw}, 32'd1);
    chk("trapop_pc", redirect_pc, 32'h100);
    @(negedge clk);
    instr_valid = 1'b0; csr_op = 2'b00;
    rd("trapop_mscratch", 12'h340, 32'h0);
    rd("trapop_mepc", 12'h341, 32'h80);
    rd("trapop_mstatus", 12'h300, 32'h80);

    // Software clear of edge pending
    op(12'h344, 2'b01, 32'h0);
    rd("mip_cleared", 12'h344, 32'h0);

    // Vectored mode, channels 1 and 2 pending together
    op(12'h305, 2'b01, 32'h201);
    rd("mtvec_vec", 12'h305, 32'h201);
    op(12'h304, 2'b01, 32'h0006_0000);
    @(negedge clk);
    irq_i = 4'b0110;
    @(negedge clk);
    irq_i = 4'b0010;
    rd("mip_ch12", 12'h344, 32'h0006_0000);
    op(12'h300, 2'b10, 32'h8);
    @(negedge clk);
    instr_valid = 1'b1; pc_in = 32'h50;
    #1;
    chk("vec_trap", {31'd0, trap_taken}, 32'd1);
    chk("vec_pc", redirect_pc, 32'h244);
    @(negedge clk);
    instr_valid = 1'b0;
    rd("vec_mcause", 12'h342, 32'h8000_0011);
    rd("vec_mepc", 12'h341, 32'h50);

    // Level channel held high: blocked by MIE=0, traps once MIE is set
    @(negedge clk);
    instr_valid = 1'b1; pc_in = 32'h60;
    #1;
    chk("lvl_masked_trap", {31'd0, trap_taken}, 32'd0);
    chk("lvl_masked_redir", {31'd0, redirect}, 32'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    op(12'h300, 2'b10, 32'h8);
    @(negedge clk);
    instr_valid = 1'b1; pc_in = 32'h64;
    #1;
    chk("lvl_trap", {31'd0, trap_taken}, 32'd1);
    chk("lvl_pc", redirect_pc, 32'h244);
    @(negedge clk);
    instr_valid = 1'b0;
    rd("lvl_mepc", 12'h341, 32'h64);

    // mip write clears edge channel 2, level channel 1 ignores it
    op(12'h344, 2'b01, 32'h0);
    rd("mip_lvl_kept", 12'h344, 32'h0002_0000);

    // Rising edge on channel 0 in the same cycle as its clear
    @(negedge clk);
    instr_valid = 1'b1; csr_addr = 12'h344; csr_op = 2'b11; csr_wdata = 32'h0001_0000; irq_i = 4'b0011;
    @(negedge clk);
    instr_valid = 1'b0; csr_op = 2'b00; irq_i = 4'b0010;
    rd("edge_beats_clear", 12'h344, 32'h0003_0000);

    // Unimplemented address, mtvec WARL, mepc alignment
    op(12'h7C0, 2'b01, 32'h1234);
    rd("unimpl", 12'h7C0, 32'h0);
    op(12'h305, 2'b01, 32'h303);
    rd("mtvec_warl", 12'h305, 32'h300);
    op(12'h341, 2'b01, 32'h123);
    rd("mepc_align", 12'h341, 32'h120);

    // Read-during-write returns the old value
    @(negedge clk);
    instr_valid = 1'b1; csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 32'h55AA;
    #1;
    chk("rdw_old", csr_rdata, 32'h0);
    @(negedge clk);
    instr_valid = 1'b0; csr_op = 2'b00;
    #1;
    chk("rdw_new", csr_rdata, 32'h55AA);

    // mcycle wrap
    @(negedge clk);
    instr_valid = 1'b1; csr_addr = 12'hB00; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    csr_addr = 12'hB80;
    @(negedge clk);
    instr_valid = 1'b0; csr_op = 2'b00;
    rd("mcycleh_ones", 12'hB80, 32'hFFFF_FFFF);
    rd("mcycle_ones", 12'hB00, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycleh_wrap", 12'hB80, 32'h0);
    @(negedge clk);
    rd("mcycle_inc", 12'hB00, 32'h1);

    // Asynchronous reset mid-count
    reset = 1'b1;
    rd("reset_mcycle", 12'hB00, 32'h0);
    rd("reset_mtvec", 12'h305, 32'h0);
    rd("reset_mip", 12'h344, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
